// File: rtl/draw_sequencer.sv
// Per-frame scheduler for the VGA framebuffer write port: runs clear, pipes and
// bird each frame (or the game-over fill once the game ends), then muxes the active client.
module draw_sequencer #(
  parameter int COLOUR_W = 3,
  parameter int TIMEOUT  = 20000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                frame_tick,
  input  logic                game_over,
  output logic                start_clr,
  output logic                start_pipe,
  output logic                start_bird,
  output logic                start_over,
  input  logic                done_clr,
  input  logic                done_pipe,
  input  logic                done_bird,
  input  logic                done_over,
  input  logic [8:0]          x_clr,
  input  logic [8:0]          x_pipe,
  input  logic [8:0]          x_bird,
  input  logic [8:0]          x_over,
  input  logic [6:0]          y_clr,
  input  logic [6:0]          y_pipe,
  input  logic [6:0]          y_bird,
  input  logic [6:0]          y_over,
  input  logic [COLOUR_W-1:0] c_clr,
  input  logic [COLOUR_W-1:0] c_pipe,
  input  logic [COLOUR_W-1:0] c_bird,
  input  logic [COLOUR_W-1:0] c_over,
  input  logic                p_clr,
  input  logic                p_pipe,
  input  logic                p_bird,
  input  logic                p_over,
  output logic [8:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun,
  output logic                timeout_err,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    PIPE  = 3'd2,
    BIRD  = 3'd3,
    OVER  = 3'd4,
    HALT  = 3'd5
  } state_t;

  localparam logic [15:0] WD_MAX = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [15:0] wd;
  logic        pending;
  logic        phase, first, done_sel, honoured, expire, complete, launch;

  // The watchdog is zero only on the entry cycle of a phase, so it doubles as the entry marker.
  always_comb begin
    phase    = (state == CLEAR) || (state == PIPE) || (state == BIRD) || (state == OVER);
    first    = phase && (wd == 16'd0);
    done_sel = 1'b0;
    case (state)
      CLEAR:   done_sel = done_clr;
      PIPE:    done_sel = done_pipe;
      BIRD:    done_sel = done_bird;
      OVER:    done_sel = done_over;
      default: done_sel = 1'b0;
    endcase
    honoured = done_sel && !first;
    expire   = phase && (wd == WD_MAX) && !honoured;
    complete = honoured || expire;
    launch   = (state == IDLE) && (pending || frame_tick);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = game_over ? OVER : CLEAR;
      CLEAR:   if (complete) state_next = game_over ? OVER : PIPE;
      PIPE:    if (complete) state_next = game_over ? OVER : BIRD;
      BIRD:    if (complete) state_next = game_over ? OVER : IDLE;
      OVER:    if (complete) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      wd          <= 16'd0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wd <= 16'd0;
      else if (phase && (wd != WD_MAX))
        wd <= wd + 16'd1;
      // A launch consumes the queued tick; a tick landing on the launch cycle re-queues.
      if (state != HALT) begin
        if (launch)
          pending <= pending && frame_tick;
        else if (frame_tick)
          pending <= 1'b1;
        if (frame_tick && pending)
          overrun <= 1'b1;
      end
      if (expire)
        timeout_err <= 1'b1;
      frame_done <= (state == BIRD) && complete;
    end
  end

  always_comb begin
    start_clr  = first && (state == CLEAR);
    start_pipe = first && (state == PIPE);
    start_bird = first && (state == BIRD);
    start_over = first && (state == OVER);
    busy       = (state != IDLE) && (state != HALT);
    state_o    = state;
  end

  // Only the active client reaches the port; idle and halted states drive zeros.
  always_comb begin
    vga_x      = 9'd0;
    vga_y      = 7'd0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state)
      CLEAR: begin
        vga_x = x_clr;  vga_y = y_clr;  vga_colour = c_clr;  vga_plot = p_clr;
      end
      PIPE: begin
        vga_x = x_pipe; vga_y = y_pipe; vga_colour = c_pipe; vga_plot = p_pipe;
      end
      BIRD: begin
        vga_x = x_bird; vga_y = y_bird; vga_colour = c_bird; vga_plot = p_bird;
      end
      OVER: begin
        vga_x = x_over; vga_y = y_over; vga_colour = c_over; vga_plot = p_over;
      end
      default: begin
        vga_x = 9'd0;   vga_y = 7'd0;   vga_colour = '0;     vga_plot = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: frame ordering, mux, queued ticks,
// watchdog, entry-cycle done, reset mid-phase and game-over halt.
module tb_draw_sequencer;

  localparam int CW = 3;
  localparam int W_CLR = 0, W_PIPE = 1, W_BIRD = 2, W_OVER = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic frame_tick = 1'b0, game_over = 1'b0;
  logic start_clr, start_pipe, start_bird, start_over;
  logic done_clr = 1'b0, done_pipe = 1'b0, done_bird = 1'b0, done_over = 1'b0;
  logic [8:0] x_clr = '0, x_pipe = '0, x_bird = '0, x_over = '0;
  logic [6:0] y_clr = '0, y_pipe = '0, y_bird = '0, y_over = '0;
  logic [CW-1:0] c_clr = '0, c_pipe = '0, c_bird = '0, c_over = '0;
  logic p_clr = 1'b0, p_pipe = 1'b0, p_bird = 1'b0, p_over = 1'b0;
  logic [8:0] vga_x;
  logic [6:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic vga_plot, busy, frame_done, overrun, timeout_err;
  logic [2:0] state_o;

  int tests = 0, errors = 0;
  int cyc = 0;
  int n_clr = 0, n_pipe = 0, n_bird = 0, n_over = 0;

  draw_sequencer #(.COLOUR_W(CW), .TIMEOUT(50)) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .game_over(game_over),
    .start_clr(start_clr), .start_pipe(start_pipe), .start_bird(start_bird), .start_over(start_over),
    .done_clr(done_clr), .done_pipe(done_pipe), .done_bird(done_bird), .done_over(done_over),
    .x_clr(x_clr), .x_pipe(x_pipe), .x_bird(x_bird), .x_over(x_over),
    .y_clr(y_clr), .y_pipe(y_pipe), .y_bird(y_bird), .y_over(y_over),
    .c_clr(c_clr), .c_pipe(c_pipe), .c_bird(c_bird), .c_over(c_over),
    .p_clr(p_clr), .p_pipe(p_pipe), .p_bird(p_bird), .p_over(p_over),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (start_clr)  n_clr  <= n_clr + 1;
    if (start_pipe) n_pipe <= n_pipe + 1;
    if (start_bird) n_bird <= n_bird + 1;
    if (start_over) n_over <= n_over + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic start_of(input int w);
    case (w)
      W_CLR:   return start_clr;
      W_PIPE:  return start_pipe;
      W_BIRD:  return start_bird;
      default: return start_over;
    endcase
  endfunction

  task automatic set_done(input int w, input logic v);
    case (w)
      W_CLR:   done_clr  = v;
      W_PIPE:  done_pipe = v;
      W_BIRD:  done_bird = v;
      default: done_over = v;
    endcase
  endtask

  task automatic wait_start(input string tag, input int w, output int t);
    int n = 0;
    while (!start_of(w) && n < 200) begin
      step();
      n++;
    end
    check({tag, "_seen"}, 32'(start_of(w)), 32'd1);
    t = cyc;
  endtask

  // Waits for the client's start, then answers with a one-cycle done lat cycles later.
  task automatic serve(input string tag, input int w, input int lat);
    int t;
    wait_start(tag, w, t);
    repeat (lat) step();
    set_done(w, 1'b1);
    step();
    set_done(w, 1'b0);
  endtask

  task automatic tick_frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    int t0, t, n, base_clr, base_bird, base_over;

    // Reset state
    repeat (3) step();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_starts", 32'({start_clr, start_pipe, start_bird, start_over}), 32'd0);
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_flags", 32'({frame_done, overrun, timeout_err}), 32'd0);
    resetn = 1'b1;
    repeat (6) step();

    // Normal frame with mux check during PIPE
    t0 = cyc;
    tick_frame();
    wait_start("clr", W_CLR, t);
    check("clr_cycle", 32'(t), 32'(t0 + 1));
    check("clr_state", 32'(state_o), 32'd1);
    check("clr_busy", 32'(busy), 32'd1);
    repeat (5) step();
    check("clr_start_once", 32'(start_clr), 32'd0);
    set_done(W_CLR, 1'b1);
    step();
    set_done(W_CLR, 1'b0);
    wait_start("pipe", W_PIPE, t);
    check("pipe_cycle", 32'(t), 32'(t0 + 7));
    x_pipe = 9'd80; y_pipe = 7'd60; c_pipe = 3'b010; p_pipe = 1'b1;
    x_clr = 9'd5; p_clr = 1'b1;
    #1;
    check("mux_x", 32'(vga_x), 32'd80);
    check("mux_y", 32'(vga_y), 32'd60);
    check("mux_colour", 32'(vga_colour), 32'd2);
    check("mux_plot", 32'(vga_plot), 32'd1);
    p_pipe = 1'b0;
    #1;
    check("mux_clr_blocked", 32'(vga_plot), 32'd0);
    repeat (5) step();
    set_done(W_PIPE, 1'b1);
    step();
    set_done(W_PIPE, 1'b0);
    wait_start("bird", W_BIRD, t);
    check("bird_cycle", 32'(t), 32'(t0 + 13));
    repeat (5) step();
    set_done(W_BIRD, 1'b1);
    step();
    set_done(W_BIRD, 1'b0);
    check("frame_done_cycle", 32'(cyc), 32'(t0 + 19));
    check("frame_done", 32'(frame_done), 32'd1);
    check("frame_idle", 32'(state_o), 32'd0);
    check("idle_plot", 32'(vga_plot), 32'd0);
    check("idle_x", 32'(vga_x), 32'd0);
    step();
    check("frame_done_pulse", 32'(frame_done), 32'd0);
    p_clr = 1'b0; x_clr = '0; x_pipe = '0; y_pipe = '0; c_pipe = '0;
    check("no_overrun_yet", 32'(overrun), 32'd0);

    // Queued ticks: two ticks during CLEAR, exactly one extra frame
    base_clr = n_clr;
    tick_frame();
    wait_start("q_clr", W_CLR, t);
    tick_frame();
    step();
    tick_frame();
    check("overrun", 32'(overrun), 32'd1);
    set_done(W_CLR, 1'b1);
    step();
    set_done(W_CLR, 1'b0);
    serve("q_pipe", W_PIPE, 2);
    serve("q_bird", W_BIRD, 2);
    serve("q2_clr", W_CLR, 2);
    serve("q2_pipe", W_PIPE, 2);
    serve("q2_bird", W_BIRD, 2);
    repeat (6) step();
    check("queued_clr_count", 32'(n_clr - base_clr), 32'd2);
    check("queued_idle", 32'(state_o), 32'd0);

    // done on entry cycle is ignored
    tick_frame();
    wait_start("e_clr", W_CLR, t);
    set_done(W_CLR, 1'b1);
    step();
    set_done(W_CLR, 1'b0);
    check("entry_done_ignored", 32'(state_o), 32'd1);
    repeat (3) step();
    check("entry_still_clear", 32'(state_o), 32'd1);
    set_done(W_CLR, 1'b1);
    step();
    set_done(W_CLR, 1'b0);
    check("entry_later_done", 32'(state_o), 32'd2);
    serve("e_pipe", W_PIPE, 1);
    serve("e_bird", W_BIRD, 1);
    step();
    check("no_timeout_yet", 32'(timeout_err), 32'd0);

    // Watchdog: no done from clear
    tick_frame();
    wait_start("wd_clr", W_CLR, t);
    n = 0;
    while (state_o == 3'd1 && n < 100) begin
      step();
      n++;
    end
    check("wd_cycles", 32'(n), 32'd50);
    check("wd_next_state", 32'(state_o), 32'd2);
    check("wd_err", 32'(timeout_err), 32'd1);
    serve("wd_pipe", W_PIPE, 1);
    serve("wd_bird", W_BIRD, 1);
    step();
    check("wd_err_sticky", 32'(timeout_err), 32'd1);

    // Reset mid-BIRD
    tick_frame();
    serve("rb_clr", W_CLR, 1);
    serve("rb_pipe", W_PIPE, 1);
    wait_start("rb_bird", W_BIRD, t);
    step();
    x_bird = 9'd7; p_bird = 1'b1;
    resetn = 1'b0;
    step();
    check("rb_state", 32'(state_o), 32'd0);
    check("rb_plot", 32'(vga_plot), 32'd0);
    check("rb_x", 32'(vga_x), 32'd0);
    check("rb_busy", 32'(busy), 32'd0);
    check("rb_flags", 32'({frame_done, overrun, timeout_err}), 32'd0);
    resetn = 1'b1;
    p_bird = 1'b0; x_bird = '0;
    base_bird = n_bird;
    repeat (4) step();
    check("rb_no_restart", 32'(n_bird - base_bird), 32'd0);

    // Game over raised during PIPE
    tick_frame();
    serve("go_clr", W_CLR, 2);
    wait_start("go_pipe", W_PIPE, t0);
    base_bird = n_bird;
    game_over = 1'b1;
    repeat (3) step();
    set_done(W_PIPE, 1'b1);
    step();
    set_done(W_PIPE, 1'b0);
    wait_start("go_over", W_OVER, t);
    check("go_over_cycle", 32'(t), 32'(t0 + 4));
    check("go_over_state", 32'(state_o), 32'd4);
    check("go_no_bird", 32'(n_bird - base_bird), 32'd0);
    serve("go_over_done", W_OVER, 3);
    check("go_halt", 32'(state_o), 32'd5);
    check("go_halt_busy", 32'(busy), 32'd0);
    base_clr = n_clr;
    base_over = n_over;
    p_over = 1'b1;
    repeat (3) begin
      tick_frame();
      step();
    end
    repeat (3) step();
    check("halt_stays", 32'(state_o), 32'd5);
    check("halt_no_starts", 32'((n_clr - base_clr) + (n_over - base_over)), 32'd0);
    check("halt_plot", 32'(vga_plot), 32'd0);
    check("halt_no_overrun", 32'(overrun), 32'd0);
    p_over = 1'b0;
    resetn = 1'b0;
    step();
    check("halt_reset", 32'(state_o), 32'd0);
    resetn = 1'b1;
    game_over = 1'b0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
